// File: rtl/fusion_sum_drain.sv
// Unpacks a captured 128-bit fusion MAC accumulator into 20-bit extended lanes, LSB lane first.
// First beat is visible the cycle after start is accepted; a beat holds steady while out_ready is low.
module fusion_sum_drain (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         sgn,
  input  logic [127:0] sum_in,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [19:0]  out_data,
  output logic [3:0]   out_lane,
  output logic         out_last,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_2B  = 2'b00;
  localparam logic [1:0] MODE_4B  = 2'b01;
  localparam logic [1:0] MODE_BAD = 2'b11;

  state_t       state_q, state_d;
  logic [127:0] sum_q;
  logic [1:0]   mode_q;
  logic         sgn_q;
  logic [3:0]   lane_q;

  logic [3:0]   last_idx;
  logic         is_last;
  logic [6:0]   off12;
  logic [7:0]   lane8;
  logic [11:0]  lane12;
  logic [19:0]  lane_ext;
  logic         beat;

  // Lane extraction depends only on captured state so the beat is stable under backpressure.
  always_comb begin
    off12  = {3'b000, lane_q} * 7'd12;
    lane8  = 8'(sum_q >> {lane_q, 3'b000});
    lane12 = 12'(sum_q >> off12);

    last_idx = 4'd0;
    lane_ext = sum_q[19:0];
    case (mode_q)
      MODE_2B: begin
        last_idx = 4'd15;
        lane_ext = {{12{sgn_q & lane8[7]}}, lane8};
      end
      MODE_4B: begin
        last_idx = 4'd3;
        lane_ext = {{8{sgn_q & lane12[11]}}, lane12};
      end
      default: begin
        last_idx = 4'd0;
        lane_ext = sum_q[19:0];
      end
    endcase
    is_last = (lane_q == last_idx);
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 20'd0;
    out_lane  = 4'd0;
    out_last  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (start) state_d = (mode == MODE_BAD) ? FIN : DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = lane_ext;
        out_lane  = lane_q;
        out_last  = is_last;
        if (out_ready && is_last) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        err     = (mode_q == MODE_BAD);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= 128'd0;
      mode_q  <= 2'd0;
      sgn_q   <= 1'b0;
      lane_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sum_q  <= sum_in;
        mode_q <= mode;
        sgn_q  <= sgn;
        lane_q <= 4'd0;
      end else if (beat && !is_last) begin
        lane_q <= lane_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fusion_sum_drain.sv
// Directed bench for fusion_sum_drain with hand-computed lane values.
module tb_fusion_sum_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic         sgn;
  logic [127:0] sum_in;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [19:0]  out_data;
  logic [3:0]   out_lane;
  logic         out_last;
  logic         done;
  logic         err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fusion_sum_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .sgn       (sgn),
    .sum_in    (sum_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Checks the presented beat, then lets it be consumed at the next edge.
  task automatic expect_beat(input string tag, input int lane, input logic [19:0] data, input logic last);
    chk({tag, "_valid"}, {19'd0, out_valid}, 20'd1);
    chk({tag, "_data"}, out_data, data);
    chk({tag, "_lane"}, {16'd0, out_lane}, 20'(lane));
    chk({tag, "_last"}, {19'd0, out_last}, {19'd0, last});
    step();
  endtask

  logic [127:0] rnd;
  logic [127:0] v;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; sgn = 1'b0; sum_in = '0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", {19'd0, in_ready}, 20'd1);
    chk("rst_out_valid", {19'd0, out_valid}, 20'd0);
    chk("rst_out_data", out_data, 20'd0);
    chk("rst_out_lane", {16'd0, out_lane}, 20'd0);
    chk("rst_out_last", {19'd0, out_last}, 20'd0);
    chk("rst_done", {19'd0, done}, 20'd0);
    chk("rst_err", {19'd0, err}, 20'd0);

    // 8bx8b signed: single beat
    rnd = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; mode = 2'b10; sgn = 1'b1; sum_in = {rnd[127:20], 20'hFFFF0};
    step();
    start = 1'b0; sum_in = '0;
    expect_beat("b8", 0, 20'hFFFF0, 1'b1);
    chk("b8_done", {19'd0, done}, 20'd1);
    chk("b8_err", {19'd0, err}, 20'd0);
    chk("b8_no_valid", {19'd0, out_valid}, 20'd0);
    chk("b8_busy", {19'd0, in_ready}, 20'd0);
    step();
    chk("b8_done_clr", {19'd0, done}, 20'd0);
    chk("b8_ready", {19'd0, in_ready}, 20'd1);

    // 4bx4b signed
    rnd = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; mode = 2'b01; sgn = 1'b1;
    sum_in = {rnd[127:48], 12'hFFF, 12'h001, 12'h7FF, 12'h800};
    step();
    start = 1'b0;
    expect_beat("b4s0", 0, 20'hFF800, 1'b0);
    expect_beat("b4s1", 1, 20'h007FF, 1'b0);
    expect_beat("b4s2", 2, 20'h00001, 1'b0);
    expect_beat("b4s3", 3, 20'hFFFFF, 1'b1);
    chk("b4s_done", {19'd0, done}, 20'd1);
    step();
    chk("b4s_ready", {19'd0, in_ready}, 20'd1);

    // 4bx4b unsigned, same data
    start = 1'b1; sgn = 1'b0;
    step();
    start = 1'b0;
    expect_beat("b4u0", 0, 20'h00800, 1'b0);
    expect_beat("b4u1", 1, 20'h007FF, 1'b0);
    expect_beat("b4u2", 2, 20'h00001, 1'b0);
    expect_beat("b4u3", 3, 20'h00FFF, 1'b1);
    chk("b4u_done", {19'd0, done}, 20'd1);
    step();

    // 2bx2b signed with a 3-cycle stall on lane 5
    for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(8'h80 + k);
    start = 1'b1; mode = 2'b00; sgn = 1'b1; sum_in = v;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) expect_beat("b2", k, {12'hFFF, 8'(8'h80 + k)}, 1'b0);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("b2_stall_valid", {19'd0, out_valid}, 20'd1);
      chk("b2_stall_data", out_data, 20'hFFF85);
      chk("b2_stall_lane", {16'd0, out_lane}, 20'd5);
      chk("b2_stall_done", {19'd0, done}, 20'd0);
      step();
    end
    out_ready = 1'b1;
    for (int k = 5; k < 16; k++) expect_beat("b2", k, {12'hFFF, 8'(8'h80 + k)}, k == 15);
    chk("b2_done", {19'd0, done}, 20'd1);
    step();
    chk("b2_done_once", {19'd0, done}, 20'd0);

    // start while busy is ignored
    start = 1'b1; mode = 2'b01; sgn = 1'b0;
    sum_in = {80'd0, 12'h004, 12'h003, 12'h002, 12'h001};
    step();
    start = 1'b0;
    expect_beat("busy0", 0, 20'h00001, 1'b0);
    start = 1'b1; mode = 2'b00; sgn = 1'b1; sum_in = {128{1'b1}};
    expect_beat("busy1", 1, 20'h00002, 1'b0);
    start = 1'b0; sum_in = '0;
    expect_beat("busy2", 2, 20'h00003, 1'b0);
    expect_beat("busy3", 3, 20'h00004, 1'b1);
    chk("busy_done", {19'd0, done}, 20'd1);
    step();
    chk("busy_done_once", {19'd0, done}, 20'd0);
    chk("busy_idle", {19'd0, in_ready}, 20'd1);
    chk("busy_no_valid", {19'd0, out_valid}, 20'd0);

    // reset at lane 7 of a 2b drain
    for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(k);
    start = 1'b1; mode = 2'b00; sgn = 1'b0; sum_in = v;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) expect_beat("rmid", k, 20'(k), 1'b0);
    chk("rmid_lane7", {16'd0, out_lane}, 20'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_valid", {19'd0, out_valid}, 20'd0);
    chk("rmid_ready", {19'd0, in_ready}, 20'd1);
    chk("rmid_done", {19'd0, done}, 20'd0);
    chk("rmid_data", out_data, 20'd0);
    chk("rmid_lane", {16'd0, out_lane}, 20'd0);
    step();
    chk("rmid_done_later", {19'd0, done}, 20'd0);
    start = 1'b1; mode = 2'b01; sgn = 1'b1; sum_in = {80'd0, 12'h444, 12'h333, 12'h222, 12'h911};
    step();
    start = 1'b0;
    expect_beat("fresh0", 0, 20'hFF911, 1'b0);
    expect_beat("fresh1", 1, 20'h00222, 1'b0);
    expect_beat("fresh2", 2, 20'h00333, 1'b0);
    expect_beat("fresh3", 3, 20'h00444, 1'b1);
    chk("fresh_done", {19'd0, done}, 20'd1);
    step();

    // reset and start together: nothing captured
    rst = 1'b1; start = 1'b1; mode = 2'b10; sum_in = 128'h12345;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_valid", {19'd0, out_valid}, 20'd0);
    chk("rst_start_ready", {19'd0, in_ready}, 20'd1);
    step();
    chk("rst_start_valid2", {19'd0, out_valid}, 20'd0);

    // invalid mode
    start = 1'b1; mode = 2'b11; sgn = 1'b1; sum_in = {128{1'b1}};
    step();
    start = 1'b0;
    chk("inv_err", {19'd0, err}, 20'd1);
    chk("inv_done", {19'd0, done}, 20'd1);
    chk("inv_valid", {19'd0, out_valid}, 20'd0);
    chk("inv_busy", {19'd0, in_ready}, 20'd0);
    step();
    chk("inv_ready", {19'd0, in_ready}, 20'd1);
    chk("inv_err_clr", {19'd0, err}, 20'd0);
    chk("inv_done_clr", {19'd0, done}, 20'd0);
    chk("inv_valid2", {19'd0, out_valid}, 20'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fusion_sum_drain.md
# fusion_sum_drain

Reader/unpacker for the packed accumulator word produced by the multi-precision fusion MAC unit. On a start request it captures the 128-bit packed `sum` together with its precision mode. It then streams each accumulator lane out, least-significant lane first, as a 20-bit sign- or zero-extended value over a valid/ready handshake. It sits between the fusion MAC array and the output buffer/writeback path.

## Interface
- No parameters; lane widths and counts are fixed by the MAC's packing format.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to capture `sum_in`/`mode`/`sgn`; accepted only when `in_ready`=1.
- `mode`  in  2  precision of `sum_in`: 2'b00 = 2bx2b, 2'b01 = 4bx4b, 2'b10 = 8bx8b, 2'b11 = invalid.
- `sgn`  in  1  1: sign-extend each lane to 20 b; 0: zero-extend.
- `sum_in`  in  128  packed accumulator word.
- `in_ready`  out  1  high in IDLE.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  20  extended lane value.
- `out_lane`  out  4  index of the current lane.
- `out_last`  out  1  current beat is the final lane.
- `done`  out  1  one-cycle pulse when a drain completes.
- `err`  out  1  one-cycle pulse when a capture had `mode`=2'b11.

## Operation
- Lane maps, with lane k at the LSB end first:
  - 8bx8b: 1 lane, `sum[19:0]`.
  - 4bx4b: 4 lanes, `sum[12k+11:12k]`.
  - 2bx2b: 16 lanes, `sum[8k+7:8k]`.
  - Bits above the last lane are ignored.
- Extension of each lane to 20 b:
  - `sgn`=1: replicate the lane MSB.
  - `sgn`=0: pad with zeros.
  - 8bx8b lanes are already 20 b; `sgn` has no effect.
- FSM states: IDLE, DRAIN, FIN.
  - IDLE: `in_ready`=1. `start`=1 captures `sum_in`, `mode` and `sgn` into internal registers and clears the lane counter.
    - Valid mode: go to DRAIN.
    - `mode`=2'b11: go to FIN and pulse `err`.
  - DRAIN: `out_valid`=1. `out_data`, `out_lane` and `out_last` are derived only from the captured registers and the lane counter.
    - On `out_valid && out_ready`: if `out_last`, go to FIN; otherwise increment the lane counter.
  - FIN: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE. `sum_in`, `mode` and `sgn` are don't-care outside the capture cycle.
- `out_data`, `out_lane` and `out_last` must not change while `out_valid`=1 and `out_ready`=0.
- `out_last` = (lane counter == lane count − 1), and is only meaningful when `out_valid`=1.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `done`=0, `err`=0, capture registers=0.
- `start` accepted at edge N: `out_valid`=1 with lane 0 visible after edge N.
- With `out_ready` held at 1, one lane per cycle:
  - 8b: 1 beat.
  - 4b: 4 beats.
  - 2b: 16 beats.
- Last handshake at edge M: `done` is high in cycle M+1, and `in_ready`=1 from M+2.
- Invalid mode accepted at edge N: `err` and `done` are both high in cycle N+1. No beats are produced, and `in_ready` returns at N+2.
- Reset asserted mid-drain: at the next edge all outputs return to their reset values. The partial drain is abandoned and no `done` pulse is issued.
- Reset and `start` asserted together: reset wins and nothing is captured.

## Test plan
- **8bx8b, signed:** `mode`=10, `sgn`=1, `sum_in[19:0]`=20'hFFFF0, upper bits random, `out_ready`=1.
  - Expect exactly one beat: `out_data`=20'hFFFF0, lane 0, `out_last`=1.
  - `done` in the following cycle.
- **4bx4b, signed then unsigned:** lanes 0..3 = 12'h800, 12'h7FF, 12'h001, 12'hFFF.
  - `sgn`=1: expect 20'hFF800, 20'h007FF, 20'h00001, 20'hFFFFF on lanes 0..3, with `out_last` only on lane 3.
  - Repeat with `sgn`=0: expect 20'h00800, 20'h007FF, 20'h00001, 20'h00FFF.
- **2bx2b with backpressure:** lane k = 8'h80+k, `sgn`=1.
  - Drop `out_ready` for 3 cycles while lane 5 is presented; lane 5 must hold 20'hFFF85 with `out_lane`=5.
  - All 16 beats arrive in order; `done` pulses once.
- **`start` while busy:** pulse `start` with a new `sum_in` during DRAIN.
  - Expect it ignored: original data completes unchanged and `done` pulses once.
- **Reset mid-drain:** assert `rst` for 1 cycle at lane 7 of a 2b drain.
  - Expect `out_valid`=0, `in_ready`=1 and no `done`.
  - A fresh `start` then drains from lane 0.
- **Invalid mode:** `mode`=11 with `start`.
  - Expect `err`=1 and `done`=1 in the same cycle, zero beats, and `in_ready` back one cycle later.
